// File: rtl/wls_pkg.sv
// ---------------------------------------------------------------------------
// wls_pkg
// Shared definitions for the wordlength search controller (wl_search_ctrl):
//   - CNT_W / ITER_W : widths of the num_int/num_frac outputs and the
//                      optional iteration counter
//   - wls_state_e    : controller states
//   - wls_phase_e    : which field is currently being shrunk
//   - sat_inc        : saturating increment for the iteration counter
// ---------------------------------------------------------------------------
package wls_pkg;

    localparam int CNT_W  = 8;
    localparam int ITER_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_REQ,
        ST_CHECK,
        ST_DONE
    } wls_state_e;

    typedef enum logic {
        PH_FRAC,
        PH_INT
    } wls_phase_e;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (v == '1) ? v : v + ITER_W'(1);
    endfunction

endpackage

// File: rtl/wl_search_ctrl.sv
// ---------------------------------------------------------------------------
// wl_search_ctrl
// Greedy wordlength search. Starting from the full datapath width it trims
// fractional bits one at a time while an external evaluator reports an error
// within thr, then trims integer bits the same way (never below one bit, so
// the sign bit survives). The last passing width is left on num_int/num_frac.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start, thr         launch pulse (IDLE only) and error threshold (latched)
//   num_int, num_frac  current integer / fractional widths to the mask stage
//   eval_req           evaluation request, held until eval_ack
//   eval_ack, err      evaluator completion pulse and its error result
//   busy, done, fail   running, one-cycle completion, full width too lossy
//   iter_cnt           evaluation count (only with WLS_ITER_CNT_EN defined)
//
// Build option: define WLS_ITER_CNT_EN to add the iter_cnt output.
// ---------------------------------------------------------------------------
module wl_search_ctrl
    import wls_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int INT_POS = 16,
    parameter int ERR_W   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ERR_W-1:0]  thr,
    output logic [CNT_W-1:0]  num_int,
    output logic [CNT_W-1:0]  num_frac,
    output logic              eval_req,
    input  logic              eval_ack,
    input  logic [ERR_W-1:0]  err,
    output logic              busy,
    output logic              done,
    output logic              fail
`ifdef WLS_ITER_CNT_EN
    ,
    output logic [ITER_W-1:0] iter_cnt
`endif
);

    localparam logic [CNT_W-1:0] INT_LOAD  = CNT_W'(MAX_LEN - INT_POS);
    localparam logic [CNT_W-1:0] FRAC_LOAD = CNT_W'(INT_POS);

    wls_state_e       state_q, state_d;
    wls_phase_e       phase_q, phase_d;
    logic             first_q, first_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] num_int_q, num_int_d;
    logic [CNT_W-1:0] num_frac_q, num_frac_d;
    logic [ERR_W-1:0] thr_q, thr_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass;
`ifdef WLS_ITER_CNT_EN
    logic [ITER_W-1:0] iter_q, iter_d;
`endif

    assign pass = (err_q <= thr_q);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        first_d    = first_q;
        fail_d     = fail_q;
        num_int_d  = num_int_q;
        num_frac_d = num_frac_q;
        thr_d      = thr_q;
        err_d      = err_q;
`ifdef WLS_ITER_CNT_EN
        iter_d     = iter_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thr_d      = thr;
                    num_int_d  = INT_LOAD;
                    num_frac_d = FRAC_LOAD;
                    phase_d    = PH_FRAC;
                    first_d    = 1'b1;
                    fail_d     = 1'b0;
`ifdef WLS_ITER_CNT_EN
                    iter_d     = '0;
`endif
                    state_d    = ST_SET;
                end
            end
            // One idle cycle so the downstream mask settles on the new widths.
            ST_SET: state_d = ST_REQ;
            ST_REQ: begin
                if (eval_ack) begin
                    err_d   = err;
`ifdef WLS_ITER_CNT_EN
                    iter_d  = sat_inc(iter_q);
`endif
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (first_q && !pass) begin
                    // Even the full width is too lossy: nothing to trim.
                    fail_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    first_d = 1'b0;
                    if (phase_q == PH_FRAC && pass && num_frac_q != '0) begin
                        num_frac_d = num_frac_q - CNT_W'(1);
                        state_d    = ST_SET;
                    end else if (phase_q == PH_FRAC || pass) begin
                        // Fractional search is over (exhausted or failed):
                        // undo a failed trim, then try the first integer trim.
                        if (phase_q == PH_FRAC && !pass) begin
                            num_frac_d = num_frac_q + CNT_W'(1);
                        end
                        phase_d = PH_INT;
                        if (num_int_q > CNT_W'(1)) begin
                            num_int_d = num_int_q - CNT_W'(1);
                            state_d   = ST_SET;
                        end else begin
                            state_d   = ST_DONE;
                        end
                    end else begin
                        // Integer trim failed: restore the last passing width.
                        num_int_d = num_int_q + CNT_W'(1);
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            phase_q    <= PH_FRAC;
            first_q    <= 1'b0;
            fail_q     <= 1'b0;
            num_int_q  <= INT_LOAD;
            num_frac_q <= FRAC_LOAD;
`ifdef WLS_ITER_CNT_EN
            iter_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            first_q    <= first_d;
            fail_q     <= fail_d;
            num_int_q  <= num_int_d;
            num_frac_q <= num_frac_d;
`ifdef WLS_ITER_CNT_EN
            iter_q     <= iter_d;
`endif
        end
    end

    // Threshold and error are pure data, always written before being used.
    always_ff @(posedge clk) begin
        thr_q <= thr_d;
        err_q <= err_d;
    end

    assign num_int  = num_int_q;
    assign num_frac = num_frac_q;
    assign eval_req = (state_q == ST_REQ);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign fail     = fail_q;
`ifdef WLS_ITER_CNT_EN
    assign iter_cnt = iter_q;
`endif

endmodule

// File: tb/tb_wl_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wl_search_ctrl
// Directed bench for wl_search_ctrl with a reference search model and an
// evaluator that answers eval_req after a fixed or random delay.
// ---------------------------------------------------------------------------
module tb_wl_search_ctrl;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] thr;
    logic [7:0]  num_int;
    logic [7:0]  num_frac;
    logic        eval_req;
    logic        eval_ack;
    logic [31:0] err;
    logic        busy;
    logic        done;
    logic        fail;
`ifdef WLS_ITER_CNT_EN
    logic [15:0] iter_cnt;
`endif

    wl_search_ctrl #(.MAX_LEN(32), .INT_POS(16), .ERR_W(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .thr      (thr),
        .num_int  (num_int),
        .num_frac (num_frac),
        .eval_req (eval_req),
        .eval_ack (eval_ack),
        .err      (err),
        .busy     (busy),
        .done     (done),
        .fail     (fail)
`ifdef WLS_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counters and reference data
    int n_cmp = 0;
    int n_fail = 0;
    int exp_ni[64];
    int exp_nf[64];
    int exp_n = 0;
    int exp_ni_fin = 0;
    int exp_nf_fin = 0;
    int exp_fail = 0;

    // Evaluator control
    int cur_sc = 0;
    int ev_en = 0;
    int ev_rand = 0;
    int ev_delay = 0;
    int spur_req = 0;
    int spur_done = 0;

    // Monitor state
    int mon_en = 0;
    int idx = 0;
    int done_cnt = 0;
    logic req_prev = 1'b0;
    logic done_prev = 1'b0;

    // Error seen by the evaluator for a given width, per scenario.
    // 0: always clean; 1: lossy when num_frac<5 or num_int<3; 2: always 100.
    function automatic logic [31:0] err_fn(input int sc, input int ni, input int nf);
        case (sc)
            0:       return 32'd0;
            1:       return (nf < 5 || ni < 3) ? 32'd20 : 32'd0;
            default: return 32'd100;
        endcase
    endfunction

    // Reference: list every width the search must evaluate, and the result.
    task automatic build_model(input int sc, input logic [31:0] t);
        int ni;
        int nf;
        bit stop;
        ni = 16;
        nf = 16;
        exp_n = 0;
        exp_fail = 0;
        exp_ni[exp_n] = ni; exp_nf[exp_n] = nf; exp_n++;
        if (err_fn(sc, ni, nf) > t) begin
            exp_fail = 1;
        end else begin
            stop = 0;
            while (nf > 0 && !stop) begin
                nf--;
                exp_ni[exp_n] = ni; exp_nf[exp_n] = nf; exp_n++;
                if (err_fn(sc, ni, nf) > t) begin
                    nf++;
                    stop = 1;
                end
            end
            stop = 0;
            while (ni > 1 && !stop) begin
                ni--;
                exp_ni[exp_n] = ni; exp_nf[exp_n] = nf; exp_n++;
                if (err_fn(sc, ni, nf) > t) begin
                    ni++;
                    stop = 1;
                end
            end
        end
        exp_ni_fin = ni;
        exp_nf_fin = nf;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Per-cycle comparison against the reference list.
    task automatic monitor();
        if (mon_en != 0) begin
            if (eval_req) begin
                if (idx >= exp_n || idx > 63) begin
                    chk("extra_eval", 32'(idx), 32'(exp_n));
                end else begin
                    chk("eval_num_int", 32'(num_int), 32'(exp_ni[idx]));
                    chk("eval_num_frac", 32'(num_frac), 32'(exp_nf[idx]));
                end
                chk("busy_in_req", 32'(busy), 32'd1);
            end
            if (req_prev && !eval_req) idx++;
            if (done) begin
                chk("done_width", 32'(done_prev), 32'd0);
                chk("final_num_int", 32'(num_int), 32'(exp_ni_fin));
                chk("final_num_frac", 32'(num_frac), 32'(exp_nf_fin));
                chk("final_fail", 32'(fail), 32'(exp_fail));
                chk("eval_count", 32'(idx), 32'(exp_n));
`ifdef WLS_ITER_CNT_EN
                chk("iter_cnt", 32'(iter_cnt), 32'(exp_n));
`endif
                done_cnt++;
            end
            req_prev  = eval_req;
            done_prev = done;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    // Evaluator: answers a request after ev_delay (or random 0..20) cycles.
    initial begin
        int wcnt;
        int dly;
        wcnt = 0;
        dly = 0;
        eval_ack = 1'b0;
        err = 32'd0;
        forever begin
            @(negedge clk);
            eval_ack = 1'b0;
            if (spur_req != spur_done) begin
                eval_ack = 1'b1;
                err = 32'd0;
                spur_done++;
            end else if (ev_en != 0 && eval_req) begin
                if (wcnt < dly) begin
                    wcnt++;
                end else begin
                    eval_ack = 1'b1;
                    err = err_fn(cur_sc, int'(num_int), int'(num_frac));
                    wcnt = 0;
                    dly = (ev_rand != 0) ? int'($urandom_range(0, 20)) : ev_delay;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic run(input int sc, input logic [31:0] t, input int rnd,
                       input int fixed_dly, input int restart);
        int cyc;
        build_model(sc, t);
        cur_sc = sc;
        ev_rand = rnd;
        ev_delay = fixed_dly;
        ev_en = 1;
        idx = 0;
        done_cnt = 0;
        req_prev = 1'b0;
        done_prev = 1'b0;
        mon_en = 1;
        thr = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        thr = 32'd0;          // must already be latched
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            tick();
            cyc++;
            if (restart != 0 && cyc == 4) start = 1'b1;
            if (restart != 0 && cyc == 5) start = 1'b0;
        end
        if (done_cnt == 0) chk("done_timeout", 32'(cyc), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("hold_num_int", 32'(num_int), 32'(exp_ni_fin));
        chk("hold_num_frac", 32'(num_frac), 32'(exp_nf_fin));
        mon_en = 0;
        ev_en = 0;
    endtask

    initial begin
        int cyc;
        rstn = 1'b0;
        start = 1'b0;
        thr = 32'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eval_req", 32'(eval_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_num_int", 32'(num_int), 32'd16);
        chk("rst_num_frac", 32'(num_frac), 32'd16);
`ifdef WLS_ITER_CNT_EN
        chk("rst_iter_cnt", 32'(iter_cnt), 32'd0);
`endif
        rstn = 1'b1;
        tick();

        // Clean evaluator: shrink all the way to 1 integer bit.
        run(0, 32'd10, 0, 3, 0);
        chk("lit0_num_int", 32'(num_int), 32'd1);
        chk("lit0_num_frac", 32'(num_frac), 32'd0);
        chk("lit0_fail", 32'(fail), 32'd0);
        chk("lit0_evals", 32'(idx), 32'd32);

        // Lossy below 5 fractional / 3 integer bits.
        run(1, 32'd10, 0, 2, 0);
        chk("lit1_num_int", 32'(num_int), 32'd3);
        chk("lit1_num_frac", 32'(num_frac), 32'd5);
        chk("lit1_fail", 32'(fail), 32'd0);

        // Full width already too lossy.
        run(2, 32'd50, 0, 1, 0);
        chk("lit2_fail", 32'(fail), 32'd1);
        chk("lit2_num_int", 32'(num_int), 32'd16);
        chk("lit2_num_frac", 32'(num_frac), 32'd16);
        chk("lit2_evals", 32'(idx), 32'd1);

        // Zero immediate ack, random-delayed acks, and a start while busy.
        run(1, 32'd10, 0, 0, 0);
        chk("lit3_num_frac", 32'(num_frac), 32'd5);
        run(1, 32'd10, 1, 0, 1);
        chk("lit4_num_int", 32'(num_int), 32'd3);
        chk("lit4_num_frac", 32'(num_frac), 32'd5);

        // Spurious ack in IDLE.
        spur_req++;
        tick();
        tick();
        tick();
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_num_int", 32'(num_int), 32'd3);
        chk("spur_num_frac", 32'(num_frac), 32'd5);
        chk("spur_fail", 32'(fail), 32'd0);
`ifdef WLS_ITER_CNT_EN
        chk("spur_iter_cnt", 32'(iter_cnt), 32'(exp_n));
`endif

        // Asynchronous reset while a request is outstanding.
        cur_sc = 0;
        ev_rand = 0;
        ev_delay = 4;
        ev_en = 1;
        thr = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(eval_req && num_frac != 8'd16) && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("reach_req", 32'(eval_req), 32'd1);
        ev_en = 0;
        rstn = 1'b0;
        #1;
        chk("arst_eval_req", 32'(eval_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_fail", 32'(fail), 32'd0);
        chk("arst_num_int", 32'(num_int), 32'd16);
        chk("arst_num_frac", 32'(num_frac), 32'd16);
`ifdef WLS_ITER_CNT_EN
        chk("arst_iter_cnt", 32'(iter_cnt), 32'd0);
`endif
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Clean run after the reset.
        run(0, 32'd10, 1, 0, 0);
        chk("lit5_num_int", 32'(num_int), 32'd1);
        chk("lit5_num_frac", 32'(num_frac), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, limit 3000000");
        $fatal(1, "timeout");
    end

endmodule
